// File: rtl/ikaopll_audio_out_pkg.sv
// Shared widths, PCM sample type and saturation helper for the audio output path.
// Optional DC blocker is enabled by defining IKAOPLL_DCBLOCK_EN.
package ikaopll_audio_pkg;

    localparam int PCM_W = 16;
    localparam int ACC_W = 13;

    typedef logic signed [PCM_W-1:0] pcm_t;

    function automatic pcm_t sat16(input logic signed [19:0] x);
        pcm_t r;
        if (x > 20'sd32767)
            r = 16'sh7fff;
        else if (x < -20'sd32768)
            r = 16'sh8000;
        else
            r = x[15:0];
        return r;
    endfunction

endpackage

// File: rtl/ikaopll_audio_out_if.sv
// Valid/ready PCM sample stream from the audio output block to its consumer.
// Master drives sample and valid; slave drives ready.
interface ikaopll_audio_out_if;
    import ikaopll_audio_pkg::*;

    logic o_SMPL_VALID;
    logic i_SMPL_READY;
    pcm_t o_SMPL;

    modport master (
        output o_SMPL_VALID,
        output o_SMPL,
        input  i_SMPL_READY
    );

    modport slave (
        input  o_SMPL_VALID,
        input  o_SMPL,
        output i_SMPL_READY
    );

endinterface

// File: rtl/ikaopll_sync_fifo.sv
// Single-clock FIFO with registered level; a write into a full FIFO is dropped
// unless a read happens in the same cycle.
module ikaopll_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int LW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          wr_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          do_wr, do_rd;

    assign empty   = (lvl_q == '0);
    assign full    = (lvl_q == LW'(DEPTH));
    assign level   = lvl_q;
    assign rd_data = mem_q[rp_q];

    always_comb begin
        do_rd   = rd_en & ~empty;
        do_wr   = wr_en & (~full | do_rd);
        wr_drop = wr_en & full & ~do_rd;
        // power-of-two depth lets the pointers wrap naturally
        wp_d    = wp_q + AW'(do_wr);
        rp_d    = rp_q + AW'(do_rd);
        lvl_d   = lvl_q + LW'(do_wr) - LW'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            lvl_q <= lvl_d;
            if (do_wr)
                mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: rtl/ikaopll_audio_out.sv
// Captures one DAC frame sum per strobe edge, scales/saturates to 16-bit PCM
// and queues it for a valid/ready consumer. IKAOPLL_DCBLOCK_EN adds a DC blocker.
module ikaopll_audio_out
    import ikaopll_audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_SHIFT = 3
) (
    input  logic                    i_EMUCLK,
    input  logic                    i_RST_n,
    input  logic                    i_ACC_SIGNED_STRB,
    input  logic signed [ACC_W-1:0] i_ACC_SIGNED,
    ikaopll_audio_out_if.master     smpl,
    output logic [6:0]              o_FIFO_LEVEL,
    output logic                    o_OVERFLOW,
    input  logic                    i_OVF_CLR
);

    logic              strb_z_q, strb_z_d;
    logic              cap_vld_q, cap_vld_d;
    logic [ACC_W-1:0]  cap_q, cap_d;
    logic              s_vld_q, s_vld_d;
    pcm_t              s_q, s_d;
    logic              ovf_q, ovf_d;
    logic signed [19:0] ext, scaled;
    logic              wr_en, wr_drop, f_full, f_empty;
    pcm_t              wr_data, rd_data;

    always_comb begin
        strb_z_d  = i_ACC_SIGNED_STRB;
        cap_vld_d = i_ACC_SIGNED_STRB & ~strb_z_q;
        cap_d     = cap_vld_d ? i_ACC_SIGNED : cap_q;
        ext       = {{(20-ACC_W){cap_q[ACC_W-1]}}, cap_q};
        scaled    = ext <<< GAIN_SHIFT;
        s_vld_d   = cap_vld_q;
        s_d       = cap_vld_q ? sat16(scaled) : s_q;
        ovf_d     = wr_drop ? 1'b1 : (i_OVF_CLR ? 1'b0 : ovf_q);
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            // held-high strobe at reset release must not look like an edge
            strb_z_q  <= 1'b1;
            cap_vld_q <= 1'b0;
            cap_q     <= '0;
            s_vld_q   <= 1'b0;
            s_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            strb_z_q  <= strb_z_d;
            cap_vld_q <= cap_vld_d;
            cap_q     <= cap_d;
            s_vld_q   <= s_vld_d;
            s_q       <= s_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef IKAOPLL_DCBLOCK_EN
    logic               d_vld_q, d_vld_d;
    pcm_t               d_q, d_d, xp_q, xp_d;
    logic signed [19:0] yp_q, yp_d, x_e, xp_e, y;

    always_comb begin
        x_e     = {{4{s_q[15]}}, s_q};
        xp_e    = {{4{xp_q[15]}}, xp_q};
        y       = x_e - xp_e + yp_q - (yp_q >>> 8);
        d_vld_d = s_vld_q;
        d_d     = s_vld_q ? sat16(y) : d_q;
        xp_d    = s_vld_q ? s_q : xp_q;
        yp_d    = s_vld_q ? y : yp_q;
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            d_vld_q <= 1'b0;
            d_q     <= '0;
            xp_q    <= '0;
            yp_q    <= '0;
        end else begin
            d_vld_q <= d_vld_d;
            d_q     <= d_d;
            xp_q    <= xp_d;
            yp_q    <= yp_d;
        end
    end

    assign wr_en   = d_vld_q;
    assign wr_data = d_q;
`else
    assign wr_en   = s_vld_q;
    assign wr_data = s_q;
`endif

    ikaopll_sync_fifo #(
        .W     (PCM_W),
        .DEPTH (FIFO_DEPTH),
        .LW    (7)
    ) u_fifo (
        .clk     (i_EMUCLK),
        .rst_n   (i_RST_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (smpl.i_SMPL_READY),
        .rd_data (rd_data),
        .level   (o_FIFO_LEVEL),
        .full    (f_full),
        .empty   (f_empty),
        .wr_drop (wr_drop)
    );

    assign smpl.o_SMPL_VALID = ~f_empty;
    assign smpl.o_SMPL       = rd_data;
    assign o_OVERFLOW        = ovf_q;

endmodule
